crc_frame_ctrl: RTL and testbench

//  Frame-level sequencer for a bit-serial CRC shift register. Accepts a byte

---
 rtl/crc_frame_ctrl_if.sv | 29 ++
 rtl/crc_frame_ctrl.sv | 113 +++++++++++
 tb/tb_crc_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_ctrl_if.sv
// crc_frame_ctrl_if
//   Groups the word-stream and result handshakes of crc_frame_ctrl.
//   s_valid/s_ready/s_data/s_last : byte stream into the CRC sequencer
//   m_valid/m_ready/m_crc/m_ok    : frame result out of the sequencer
//   modport slave  : the CRC sequencer's view
//   modport master : the environment's view (word source + result sink)
interface crc_frame_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_crc;
  logic              m_ok;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_ok
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_ok
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl
//   Frame-level sequencer around a bit-serial Galois CRC register. Each
//   accepted word is shifted MSB-first into the CRC, one bit per clock. When
//   the word flagged last has been shifted, the frame CRC and a residue match
//   are held on the result handshake until consumed.
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : crc_frame_ctrl_if.slave (word stream in, result out)
//   busy  : frame in progress or result pending
//
// state | meaning
// IDLE  | ready for the next word (s_ready=1)
// SHIFT | serialising the latched word into the CRC, DATA_W cycles
// DONE  | frame result presented, waiting for m_ready
module crc_frame_ctrl #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = 16'h8005,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] RESIDUE = '0,
  parameter int               DATA_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  crc_frame_ctrl_if.slave     bus,
  output logic                busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  crc;
  logic [DATA_W-1:0] shreg;
  logic              last_q;
  logic              frame_open;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              release_res;
  logic              cnt_tc;
  logic              fb;
  logic [WIDTH-1:0]  crc_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the bit counter runs down and the word ends at zero
  assign cnt_tc = (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.s_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt_tc) state_nxt = last_q ? DONE : IDLE;
      DONE:    if (bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.s_ready = (state == IDLE);
    bus.m_valid = (state == DONE);
    bus.m_crc   = crc;
    bus.m_ok    = (state == DONE) && (crc == RESIDUE);
    busy        = frame_open || (state != IDLE);
  end

  assign accept      = (state == IDLE) && bus.s_valid;
  assign release_res = (state == DONE) && bus.m_ready;

  // Galois step: incoming bit combined with the register MSB selects feedback
  assign fb      = shreg[DATA_W-1] ^ crc[WIDTH-1];
  assign crc_nxt = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc        <= INIT;
      shreg      <= '0;
      last_q     <= 1'b0;
      frame_open <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        shreg      <= bus.s_data;
        last_q     <= bus.s_last;
        cnt        <= CNT_LOAD;
        frame_open <= 1'b1;
      end
      if (state == SHIFT) begin
        shreg <= shreg << 1;
        crc   <= crc_nxt;
        if (!cnt_tc) cnt <= cnt - 1'b1;
      end
      if (release_res) begin
        crc        <= INIT;
        frame_open <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl
//   Directed and randomized checks of crc_frame_ctrl at default parameters
//   (CRC-16, poly 8005, init 0, residue 0, byte input). Expected CRCs come
//   from a bytewise polynomial-division reference function.
module tb_crc_frame_ctrl;
  logic clk;
  logic rst;
  logic busy;

  crc_frame_ctrl_if #(.WIDTH(16), .DATA_W(8)) bus ();

  crc_frame_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frm [0:15];
  int         frm_len;

  // Reference: message polynomial times x^16 mod (x^16 + POLY), init 0,
  // processed one byte at a time.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] model_frame();
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < frm_len; i++) r = crc_byte(r, frm[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", (n < 100), 1);
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    bus.s_last  = $urandom;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm_len; i++) begin
      send_word(frm[i], (i == frm_len - 1));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic take_result(input string tag, input logic [15:0] exp_crc, input int stall);
    int n;
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_mvalid"}, bus.m_valid, 1);
    chk({tag, "_crc"}, bus.m_crc, exp_crc);
    chk({tag, "_ok"}, bus.m_ok, (exp_crc == 16'h0000));
    repeat (stall) tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk({tag, "_mvalid_clr"}, bus.m_valid, 0);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    logic [15:0] hold_crc;
    logic [15:0] exp_crc;
    logic [7:0]  w3 [0:2];
    int          acc_cyc [0:2];
    int          k;
    int          cyc;
    int          pulses;
    logic        rdy;

    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_crc", bus.m_crc, 16'h0000);
    chk("rst_busy", busy, 0);

    // 1: single word 01, exact result latency
    send_word(8'h01, 1'b1);
    chk("t1_busy", busy, 1);
    chk("t1_s_ready", bus.s_ready, 0);
    repeat (7) tick();
    chk("t1_mvalid_early", bus.m_valid, 0);
    tick();
    chk("t1_mvalid_on_time", bus.m_valid, 1);
    take_result("t1", 16'h8005, 0);

    // 2: "123456789"
    frm_len = 9;
    for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    send_frame();
    take_result("t2", 16'hFEE8, 1);

    // 3: same frame with its CRC appended
    frm[9]  = 8'hFE;
    frm[10] = 8'hE8;
    frm_len = 11;
    send_frame();
    take_result("t3", 16'h0000, 0);

    // 4: result stall with a pending word on the input
    frm[0]  = 8'hC3;
    frm_len = 1;
    send_frame();
    while (bus.m_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t4_mvalid", bus.m_valid, 1);
    hold_crc = model_frame();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold_mvalid", bus.m_valid, 1);
      chk("t4_hold_crc", bus.m_crc, hold_crc);
      chk("t4_hold_sready", bus.s_ready, 0);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("t4_released", bus.m_valid, 0);
    send_word(8'hAA, 1'b1);
    frm[0] = 8'hAA;
    take_result("t4_next", model_frame(), 0);

    // 5: reset during the 4th shift cycle
    send_word(8'h5A, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("t5_rst_mvalid", bus.m_valid, 0);
    chk("t5_rst_crc", bus.m_crc, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_sready", bus.s_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_mvalid", bus.m_valid, 0);
    chk("t5_crc", bus.m_crc, 16'h0000);
    tick();
    send_word(8'h01, 1'b1);
    take_result("t5_new", 16'h8005, 0);

    // 6: s_valid held across a 3-word frame
    for (int i = 0; i < 3; i++) w3[i] = 8'($urandom);
    k = 0;
    cyc = 0;
    pulses = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w3[0];
    bus.s_last  = 1'b0;
    while (k < 3 && cyc < 100) begin
      rdy = bus.s_ready;
      if (rdy) pulses++;
      tick();
      if (rdy) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          bus.s_data = w3[k];
          bus.s_last = (k == 2);
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      cyc++;
    end
    chk("t6_words", k, 3);
    chk("t6_ready_pulses", pulses, 3);
    chk("t6_gap01", acc_cyc[1] - acc_cyc[0], 9);
    chk("t6_gap12", acc_cyc[2] - acc_cyc[1], 9);
    for (int i = 0; i < 3; i++) frm[i] = w3[i];
    frm_len = 3;
    take_result("t6", model_frame(), 2);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      frm_len = $urandom_range(1, 6);
      for (int i = 0; i < frm_len; i++) frm[i] = 8'($urandom);
      exp_crc = model_frame();
      send_frame();
      take_result("rnd", exp_crc, $urandom_range(0, 4));
    end

    // Random frame followed by its own CRC must leave the residue
    frm_len = $urandom_range(2, 6);
    for (int i = 0; i < frm_len; i++) frm[i] = 8'($urandom);
    exp_crc = model_frame();
    frm[frm_len]     = exp_crc[15:8];
    frm[frm_len + 1] = exp_crc[7:0];
    frm_len = frm_len + 2;
    send_frame();
    take_result("rnd_residue", 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial cyc_guard: begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
